// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and default widths shared by the ALU execution unit.
package alu_pkg;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: request/response handshake between decode (master) and the ALU unit (slave).
interface alu_seq_unit_if #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
);
    logic               req_valid;
    logic               req_ready;
    logic [4:0]         req_opcode;
    logic [SHAMT_W-1:0] req_shamt;
    logic [DATA_W-1:0]  req_a;
    logic [DATA_W-1:0]  req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_result;
    logic               rsp_isNotEqual;
    logic               rsp_isLessThan;
    logic               rsp_overflow;
    modport master (
        output req_valid, req_opcode, req_shamt, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_isNotEqual, rsp_isLessThan, rsp_overflow
    );
    modport slave (
        input  req_valid, req_opcode, req_shamt, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_isNotEqual, rsp_isLessThan, rsp_overflow
    );
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: W-bit adder/subtractor (A + ~B + 1 when subtracting) with signed overflow.
module alu_addsub #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);
    logic [W-1:0] w_b;
    assign w_b   = i_sub ? ~i_b : i_b;
    assign o_sum = i_a + w_b + W'(i_sub);
    assign o_ovf = (i_a[W-1] == w_b[W-1]) && (o_sum[W-1] != i_a[W-1]);
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked registered ALU; serial 1-bit/cycle shifts unless ALU_FAST_SHIFT_EN
// is defined, which swaps in a single-cycle barrel shifter.
module alu_seq_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    alu_seq_unit_if.slave bus
);
    import alu_pkg::*;
    state_t             r_state;
    logic [4:0]         r_op;
    logic [SHAMT_W-1:0] r_shamt;
    logic [DATA_W-1:0]  r_a, r_b, r_result;
    logic               r_req_ready, r_rsp_valid, r_ne, r_lt, r_ovf;
    logic [DATA_W-1:0]  w_sum, w_diff, w_shifted, w_res;
    logic               w_ovf, w_ovf_cmp, w_is_arith, w_is_shift;
`ifndef ALU_FAST_SHIFT_EN
    logic [SHAMT_W-1:0] r_cnt;
`endif
    alu_addsub #(.W(DATA_W)) u_res (
        .i_a(r_a), .i_b(r_b), .i_sub(r_op == OP_SUB), .o_sum(w_sum), .o_ovf(w_ovf)
    );
    // compare flags always come from A-B regardless of opcode
    alu_addsub #(.W(DATA_W)) u_cmp (
        .i_a(r_a), .i_b(r_b), .i_sub(1'b1), .o_sum(w_diff), .o_ovf(w_ovf_cmp)
    );
    assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_is_shift = (r_op == OP_SLL) || (r_op == OP_SRA);
`ifdef ALU_FAST_SHIFT_EN
    logic [DATA_W-1:0] w_sra;
    assign w_sra     = $signed(r_a) >>> r_shamt;
    assign w_shifted = (r_op == OP_SLL) ? (r_a << r_shamt) : w_sra;
`else
    // serial mode seeds the shift register with A; shamt=0 therefore returns A
    assign w_shifted = r_a;
`endif
    assign w_res = w_is_arith ? w_sum :
                   (r_op == OP_AND) ? (r_a & r_b) :
                   (r_op == OP_OR) ? (r_a | r_b) :
                   w_is_shift ? w_shifted : '0;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_ne        <= 1'b0;
            r_lt        <= 1'b0;
            r_ovf       <= 1'b0;
            r_op        <= '0;
            r_shamt     <= '0;
            r_a         <= '0;
            r_b         <= '0;
`ifndef ALU_FAST_SHIFT_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_op        <= bus.req_opcode;
                    r_shamt     <= bus.req_shamt;
                    r_a         <= bus.req_a;
                    r_b         <= bus.req_b;
                    r_req_ready <= 1'b0;
                    r_state     <= EXEC;
                end
                EXEC: begin
                    r_result <= w_res;
                    r_ne     <= |w_diff;
                    r_lt     <= w_diff[DATA_W-1] ^ w_ovf_cmp;
                    r_ovf    <= w_is_arith & w_ovf;
`ifndef ALU_FAST_SHIFT_EN
                    if (w_is_shift && r_shamt != '0) begin
                        r_cnt   <= r_shamt;
                        r_state <= SHIFT;
                    end else
`endif
                    begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                SHIFT: begin
                    r_result <= (r_op == OP_SLL) ? {r_result[DATA_W-2:0], 1'b0}
                                                 : {r_result[DATA_W-1], r_result[DATA_W-1:1]};
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
`endif
                DONE: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.req_ready      = r_req_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_result     = r_result;
    assign bus.rsp_isNotEqual = r_ne;
    assign bus.rsp_isLessThan = r_lt;
    assign bus.rsp_overflow   = r_ovf;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed table, handshake/reset corner cases and randomized ops vs. a plain-arithmetic model.
module tb_alu_seq_unit;
    import alu_pkg::*;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;
    alu_seq_unit_if bus ();
    alu_seq_unit dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    typedef struct {
        logic [4:0]  op;
        logic [4:0]  sh;
        logic [31:0] a, b, res;
        logic        ne, lt, ov;
    } vec_t;
    vec_t tbl[13];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    function automatic vec_t model(input logic [4:0] op, input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        longint sa, sb, sr;
        logic signed [31:0] ta, r32;
        sa = $signed(a);
        sb = $signed(b);
        ta = a;
        v.op = op; v.sh = sh; v.a = a; v.b = b;
        v.ne = (a != b);
        v.lt = (sa < sb);
        v.ov = 1'b0;
        v.res = '0;
        sr = 0;
        if (op == OP_ADD) begin sr = sa + sb; v.res = a + b; end
        if (op == OP_SUB) begin sr = sa - sb; v.res = a - b; end
        if (op == OP_AND) v.res = a & b;
        if (op == OP_OR)  v.res = a | b;
        if (op == OP_SLL) v.res = a << sh;
        if (op == OP_SRA) v.res = ta >>> sh;
        r32 = v.res;
        if (op == OP_ADD || op == OP_SUB) v.ov = (sr != longint'(r32));
        return v;
    endfunction
    function automatic int exp_lat(input logic [4:0] op, input logic [4:0] sh);
`ifdef ALU_FAST_SHIFT_EN
        return 2 + 0 * int'(op) + 0 * int'(sh);
`else
        return ((op == OP_SLL || op == OP_SRA) && sh != 0) ? 2 + int'(sh) : 2;
`endif
    endfunction
    task automatic issue(input vec_t v, input string nm);
        int n;
        n = 0;
        while (!bus.req_ready && n < 60) begin @(posedge clock); #1; n++; end
        chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_opcode = v.op; bus.req_shamt = v.sh; bus.req_a = v.a; bus.req_b = v.b;
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_opcode = 5'($urandom); bus.req_shamt = 5'($urandom);
        bus.req_a = $urandom; bus.req_b = $urandom;
    endtask
    task automatic run_op(input vec_t v, input string nm, input int hold);
        int n;
        issue(v, nm);
        n = 1;
        while (!bus.rsp_valid && n < 40) begin @(posedge clock); #1; n++; end
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat(v.op, v.sh)));
        for (int c = 0; c <= hold; c++) begin
            chk({nm, "_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({nm, "_busy"}, 32'(bus.req_ready), 32'd0);
            chk({nm, "_res"}, bus.rsp_result, v.res);
            chk({nm, "_flags"}, 32'({bus.rsp_isNotEqual, bus.rsp_isLessThan, bus.rsp_overflow}), 32'({v.ne, v.lt, v.ov}));
            if (c < hold) begin @(posedge clock); #1; end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        chk({nm, "_handoff"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
    endtask
    initial begin
        vec_t v;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req_opcode = '0; bus.req_shamt = '0; bus.req_a = '0; bus.req_b = '0;
        tbl[0]  = '{OP_ADD, 5'd0,  32'h40000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{OP_SUB, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{OP_SUB, 5'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{OP_AND, 5'd0,  32'h80000001, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{OP_OR,  5'd0,  32'h0FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{OP_SLL, 5'd31, 32'h00000001, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{OP_SRA, 5'd4,  32'h80000000, 32'h00000000, 32'hF8000000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{OP_SLL, 5'd0,  32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{5'd6,   5'd3,  32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{5'd31,  5'd0,  32'h00000003, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{OP_ADD, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{OP_SRA, 5'd31, 32'h7FFFFFF0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{OP_SRA, 5'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        #12;
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_result", bus.rsp_result, 32'd0);
        chk("reset_flags", 32'({bus.rsp_isNotEqual, bus.rsp_isLessThan, bus.rsp_overflow}), 32'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("tbl%0d", i), (i == 0) ? 10 : 0);
        issue(model(OP_SLL, 5'd20, 32'hA5A5A5A5, 32'h1), "rst_mid");
        repeat (5) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_result", bus.rsp_result, 32'd0);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        run_op(model(OP_ADD, 5'd0, 32'd1, 32'd1), "post_rst_add", 0);
        for (int i = 0; i < 150; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
            v = model(op, 5'($urandom), $urandom, ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom);
            run_op(v, $sformatf("rnd%0d", i), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
